// File: rtl/nes_pkg.sv
// Shared NES bus constants and the OAM DMA state type.
package nes_pkg;

  localparam logic [15:0] OAMDMA_REG_ADDR = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR    = 16'h2004;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } oam_dma_state_e;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA: a write to 0x4014 copies page {page,00..FF} into OAMDATA, halting the CPU.
// Define OAM_DMA_ALIGN_EN to insert an ALIGN cycle when the halt lands on an odd clock.
module oam_dma
  import nes_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_write,
  input  logic [7:0]  dma_rdata,
  output logic [7:0]  dma_wdata,
  output logic        dma_done
);

  oam_dma_state_e state, state_nxt;
  logic [7:0]     page;
  logic [7:0]     idx;
  logic           trigger;

  assign trigger = (state == IDLE) && cpu_wr && (cpu_addr == OAMDMA_REG_ADDR);

`ifdef OAM_DMA_ALIGN_EN
  logic parity;

  // Free-running clock parity, independent of the transfer state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) parity <= 1'b0;
    else          parity <= ~parity;
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      page     <= '0;
      idx      <= '0;
      dma_done <= 1'b0;
    end else begin
      if (trigger) begin
        page <= cpu_wdata;
        idx  <= '0;
      end else if (state == WRITE) begin
        idx <= idx + 8'd1;
      end
      dma_done <= (state == WRITE) && (idx == 8'hFF);
    end
  end

  always_comb begin
    state_nxt  = state;
    cpu_rdy    = 1'b0;
    dma_active = 1'b1;
    dma_addr   = '0;
    dma_write  = 1'b0;
    dma_wdata  = '0;
    unique case (state)
      IDLE: begin
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;
        if (trigger) state_nxt = HALT;
      end
      HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        state_nxt = parity ? ALIGN : READ;
`else
        state_nxt = READ;
`endif
      end
      ALIGN: state_nxt = READ;
      READ: begin
        dma_addr  = {page, idx};
        state_nxt = WRITE;
      end
      WRITE: begin
        dma_addr  = OAMDATA_ADDR;
        dma_write = 1'b1;
        dma_wdata = dma_rdata;
        state_nxt = (idx == 8'hFF) ? IDLE : READ;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: random SRAM image, scoreboard of expected reads/writes and transfer lengths.
module tb_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_write;
  logic [7:0]  dma_rdata = '0;
  logic [7:0]  dma_wdata;
  logic        dma_done;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] exp_raddr [$];
  logic [7:0]  exp_wdata [$];
  int          exp_len [$];
  int unsigned cyc;

  logic        prev_rdy = 1'b1;
  logic [15:0] prev_addr = '0;
  int          run = 0;

  oam_dma dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdy    (cpu_rdy),
    .dma_active (dma_active),
    .dma_addr   (dma_addr),
    .dma_write  (dma_write),
    .dma_rdata  (dma_rdata),
    .dma_wdata  (dma_wdata),
    .dma_done   (dma_done)
  );

  always #5 clock = ~clock;

  // SRAM model: one-cycle read latency.
  always @(posedge clock) dma_rdata <= mem[dma_addr];

  // Clock edges seen since reset released; its LSB is the expected parity.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        exp_raddr.delete();
        exp_wdata.delete();
        exp_len.delete();
        prev_rdy = 1'b1;
        run = 0;
      end else begin
        if (dma_write) begin
          check("write_addr", dma_addr, 16'h2004);
          if (exp_wdata.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=%0h required=none", dma_wdata);
          end else begin
            check("read_addr", prev_addr, exp_raddr.pop_front());
            check("write_data", dma_wdata, exp_wdata.pop_front());
          end
        end
        check("active_vs_rdy", dma_active, !cpu_rdy);
        if (cpu_rdy) check("idle_outputs", {dma_write, dma_addr, dma_wdata}, '0);
        check("dma_done", dma_done, !prev_rdy && cpu_rdy);
        if (!cpu_rdy) begin
          run++;
        end else if (!prev_rdy) begin
          check("xfer_cycles", run, (exp_len.size() != 0) ? exp_len.pop_front() : -1);
          check("writes_left", exp_wdata.size(), 0);
          run = 0;
        end
        prev_rdy  = cpu_rdy;
        prev_addr = dma_addr;
      end
    end
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_wr = 1'b1;
    cpu_addr = a;
    cpu_wdata = d;
    @(negedge clock);
    cpu_wr = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!cpu_rdy && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("xfer_finished", cpu_rdy, 1'b1);
    @(negedge clock);
  endtask

  // want_par: parity value in HALT (0/1), or -1 for whatever comes.
  task automatic run_dma(input logic [7:0] page, input int want_par, input bit wait_done);
    bit par;
    int guard = 0;
    if (want_par >= 0)
      while (int'((cyc + 1) % 2) != want_par && guard < 4) begin
        @(negedge clock);
        guard++;
      end
    par = ((cyc + 1) % 2) == 1;
    for (int i = 0; i < 256; i++) begin
      exp_raddr.push_back({page, 8'(i)});
      exp_wdata.push_back(mem[{page, 8'(i)}]);
    end
    exp_len.push_back((ALIGN_EN && par) ? 514 : 513);
    cpu_write(16'h4014, page);
    check("triggered", cpu_rdy, 1'b0);
    if (wait_done) wait_idle(600);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    repeat (3) @(negedge clock);
    check("reset_outputs", {cpu_rdy, dma_active, dma_write, dma_addr, dma_wdata, dma_done},
          {1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0});
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // Page 0x02 with both halt parities.
    run_dma(8'h02, 0, 1'b1);
    run_dma(8'h02, 1, 1'b1);

    // Second write to 0x4014 mid-transfer must be ignored.
    run_dma(8'h02, -1, 1'b0);
    repeat (98) @(negedge clock);
    cpu_write(16'h4014, 8'h07);
    wait_idle(600);

    // Non-trigger bus activity.
    cpu_write(16'h4015, 8'h02);
    check("no_trig_4015", cpu_rdy, 1'b1);
    cpu_addr = 16'h4014;
    cpu_wdata = 8'h02;
    @(negedge clock);
    cpu_addr = '0;
    cpu_wdata = '0;
    check("no_trig_read", cpu_rdy, 1'b1);
    repeat (2) @(negedge clock);
    check("still_idle", cpu_rdy, 1'b1);

    // Reset asserted during the idx=0x40 write.
    begin
      int n = 0;
      int guard = 0;
      run_dma(8'h11, -1, 1'b0);
      while (guard < 600) begin
        @(negedge clock);
        guard++;
        if (dma_write) n++;
        if (dma_write && n == 8'h41) break;
      end
      check("reached_idx40", n, 8'h41);
      #2 reset_n = 1'b0;
      #1;
      check("abort_rdy", cpu_rdy, 1'b1);
      check("abort_write", dma_write, 1'b0);
      check("abort_active", dma_active, 1'b0);
      @(negedge clock);
      @(negedge clock);
      #1 reset_n = 1'b1;
      repeat (4) @(negedge clock);
      run_dma(8'h11, -1, 1'b1);
    end

    // Top page, final read at 0xFFFF.
    run_dma(8'hFF, -1, 1'b1);

    // Random pages, parities and gaps.
    for (int t = 0; t < 4; t++) begin
      repeat ($urandom_range(0, 5)) @(negedge clock);
      run_dma(8'($urandom), int'($urandom_range(0, 1)), 1'b1);
    end

    repeat (3) @(negedge clock);
    check("all_reads_seen", exp_raddr.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have port clock, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port cpu_wr, input, 1 bit: CPU bus write strobe.
REQ-004 SHALL have port cpu_addr, input, 16 bits: CPU bus address.
REQ-005 SHALL have port cpu_wdata, input, 8 bits: CPU bus write data.
REQ-006 SHALL have port cpu_rdy, output, 1 bit: low halts the CPU while DMA owns the bus.
REQ-007 SHALL have port dma_active, output, 1 bit: high while DMA drives the bus.
REQ-008 SHALL have port dma_addr, output, 16 bits: DMA bus address.
REQ-009 SHALL have port dma_write, output, 1 bit: DMA write strobe.
REQ-010 SHALL have port dma_rdata, input, 8 bits: SRAM read data, valid one cycle after the address is presented.
REQ-011 SHALL have port dma_wdata, output, 8 bits: data written to OAMDATA.
REQ-012 SHALL have port dma_done, output, 1 bit: one-cycle pulse after the final transfer.

Function
REQ-013 SHALL trigger when the unit is in IDLE and cpu_wr=1 with cpu_addr=0x4014 at a clock edge, latching page=cpu_wdata.
REQ-014 SHALL use the states IDLE, HALT, ALIGN, READ and WRITE.
REQ-015 SHALL apply these transitions: IDLE->HALT on trigger; HALT->ALIGN if parity=1, else HALT->READ; ALIGN->READ; READ->WRITE; WRITE->READ if idx!=0xFF, else WRITE->IDLE.
REQ-016 SHALL keep an internal parity bit that toggles every clock from reset, regardless of state.
REQ-017 SHALL, in READ, drive dma_addr={page,idx} with dma_write=0.
REQ-018 SHALL, in WRITE, drive dma_addr=0x2004, dma_write=1 and dma_wdata=dma_rdata, passed through combinationally without a holding register.
REQ-019 SHALL hold idx as an 8-bit counter: cleared on trigger, incremented at the end of each WRITE, wrapping 0xFF->0x00 on the final WRITE.
REQ-020 SHALL drive cpu_rdy=0 and dma_active=1 in HALT, ALIGN, READ and WRITE, and cpu_rdy=1 and dma_active=0 in IDLE.
REQ-021 SHALL drive dma_addr=0 and dma_wdata=0 whenever the unit is in IDLE or HALT/ALIGN, apart from the READ/WRITE cases above.
REQ-022 SHALL pulse dma_done for exactly the first IDLE cycle after the final WRITE.
REQ-023 SHALL take 513 cycles from trigger to the end of the final WRITE if parity=0 in HALT, and 514 cycles if parity=1 (with ALIGN enabled).
REQ-024 SHALL ignore writes to 0x4014 while not in IDLE, leaving page unchanged.
REQ-025 SHALL accept a trigger on the same edge that ends the final WRITE only on a later cycle: IDLE must be observed for one cycle first.
REQ-026 SHALL handle page=0xFF without special casing, with the final read address 0xFFFF.

Reset
REQ-027 SHALL, while reset_n=0, force state=IDLE, idx=0, page=0, parity=0, cpu_rdy=1, dma_active=0, dma_write=0, dma_addr=0, dma_wdata=0 and dma_done=0.
REQ-028 SHALL abort a transfer immediately on reset asserted mid-transfer, with no partial write strobe after assertion and no dma_done pulse.

Configuration
REQ-029 SHALL, with OAM_DMA_ALIGN_EN defined, insert the ALIGN state when parity=1 in HALT.
REQ-030 SHALL, without OAM_DMA_ALIGN_EN, always go HALT->READ, giving a fixed 513-cycle transfer; the parity bit may then be omitted.

Structure
REQ-031 SHALL take the constants OAMDMA_REG_ADDR=0x4014, OAMDATA_ADDR=0x2004 and the state enum type from the shared package nes_pkg.
REQ-032 SHALL be a single flat module with no sub-module; the counter and FSM are local.

Verification
REQ-033 SHALL verify: page=0x02, parity=0 at HALT -> cpu_rdy low for exactly 513 cycles, 256 writes to 0x2004 carrying SRAM bytes 0x0200..0x02FF in order, one dma_done pulse.
REQ-034 SHALL verify: same stimulus with parity=1 -> 514 cycles with OAM_DMA_ALIGN_EN defined, 513 cycles without it.
REQ-035 SHALL verify: a second write of 0x07 to 0x4014 at cycle 100 of a transfer -> ignored, all reads remain in page 0x02.
REQ-036 SHALL verify: reset_n pulled low at idx=0x40 in WRITE -> same cycle cpu_rdy=1, dma_write=0; no dma_done; next trigger restarts at idx=0.
REQ-037 SHALL verify: page=0xFF -> last READ address 0xFFFF, idx wraps to 0x00, FSM returns to IDLE.
REQ-038 SHALL verify: write to 0x4015 or a CPU read of 0x4014 -> no trigger, cpu_rdy stays 1.
